// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster greyscale stream, built from two line buffers.
// Optional WINGEN_LAST_EN adds a win_last flag on the final window of each frame.
module window_gen #(
    parameter int unsigned IMG_W = 298,
    parameter int unsigned IMG_H = 398
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic [7:0] win0,
    output logic [7:0] win1,
    output logic [7:0] win2,
    output logic [7:0] win3,
    output logic [7:0] win4,
    output logic [7:0] win5,
    output logic [7:0] win6,
    output logic [7:0] win7,
    output logic [7:0] win8,
`ifdef WINGEN_LAST_EN
    output logic       win_last,
`endif
    output logic       win_valid
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0] lb_a [IMG_W];
    logic [7:0] lb_b [IMG_W];

    logic [7:0] top_c;
    logic [7:0] mid_c;
    logic       col_end_c;
    logic       row_end_c;
    logic       in_win_c;

    assign top_c     = lb_a[col];
    assign mid_c     = lb_b[col];
    assign col_end_c = (col == CW'(IMG_W - 1));
    assign row_end_c = (row == RW'(IMG_H - 1));
    // Columns 0/1 would splice in the previous line's tail, so they never form a window.
    assign in_win_c  = (row >= RW'(2)) && (col >= CW'(2));

    // Raster position of the pixel currently being accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_end_c) begin
                col <= '0;
                row <= row_end_c ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are left unreset; the row>=2 rule masks stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && pix_valid) begin
            lb_a[col] <= mid_c;
            lb_b[col] <= pix_in;
        end
    end

    // Tap register shifts left one column per accepted pixel and holds on stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win0      <= '0;
            win1      <= '0;
            win2      <= '0;
            win3      <= '0;
            win4      <= '0;
            win5      <= '0;
            win6      <= '0;
            win7      <= '0;
            win8      <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= pix_valid && in_win_c;
            if (pix_valid) begin
                win0 <= win1;
                win1 <= win2;
                win2 <= top_c;
                win3 <= win4;
                win4 <= win5;
                win5 <= mid_c;
                win6 <= win7;
                win7 <= win8;
                win8 <= pix_in;
            end
        end
    end

`ifdef WINGEN_LAST_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_last <= 1'b0;
        end else begin
            win_last <= pix_valid && in_win_c && row_end_c && col_end_c;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen: a 5x4 instance for directed frame/stall/reset cases
// and a default-size instance streaming one full ramp frame.
module tb_window_gen;

    localparam int unsigned SW = 5;
    localparam int unsigned SH = 4;
    localparam int unsigned DW = 298;
    localparam int unsigned DH = 398;

    typedef struct packed {
        logic [8:0][7:0] w;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [7:0]      pix_s, pix_d;
    logic            pv_s, pv_d;
    logic [8:0][7:0] ws_s, ws_d;
    logic            wv_s, wv_d;
`ifdef WINGEN_LAST_EN
    logic            wl_s, wl_d;
`endif

    window_gen #(.IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_s), .pix_valid(pv_s),
        .win0(ws_s[0]), .win1(ws_s[1]), .win2(ws_s[2]),
        .win3(ws_s[3]), .win4(ws_s[4]), .win5(ws_s[5]),
        .win6(ws_s[6]), .win7(ws_s[7]), .win8(ws_s[8]),
`ifdef WINGEN_LAST_EN
        .win_last(wl_s),
`endif
        .win_valid(wv_s)
    );

    window_gen dut_d (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_d), .pix_valid(pv_d),
        .win0(ws_d[0]), .win1(ws_d[1]), .win2(ws_d[2]),
        .win3(ws_d[3]), .win4(ws_d[4]), .win5(ws_d[5]),
        .win6(ws_d[6]), .win7(ws_d[7]), .win8(ws_d[8]),
`ifdef WINGEN_LAST_EN
        .win_last(wl_d),
`endif
        .win_valid(wv_d)
    );

    exp_t       q_s[$];
    exp_t       q_d[$];
    logic [7:0] seq_s[$];
    logic [7:0] img_s [SH][SW];
    int         n_vec = 0;
    int         n_err = 0;
    int         r_s = 0, c_s = 0, r_d = 0, c_d = 0;
    int         cnt_d = 0;
    logic [7:0] last8_d = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pd(input int r, input int c);
        return 8'((r * int'(DW) + c) % 256);
    endfunction

    // Small-instance monitor: every presented window must match the next queued one.
    always @(negedge clk) begin
        exp_t e;
        if (wv_s) begin
            if (q_s.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL small_unexpected_window: got win8=%0d required no window", ws_s[8]);
            end else begin
                e = q_s.pop_front();
                check("small_window", 72'(ws_s), 72'(e.w));
`ifdef WINGEN_LAST_EN
                check("small_last", 72'(wl_s), 72'(e.last));
`endif
                seq_s.push_back(ws_s[8]);
            end
        end
`ifdef WINGEN_LAST_EN
        else check("small_last_idle", 72'(wl_s), 72'(0));
`endif
    end

    always @(negedge clk) begin
        exp_t e;
        if (wv_d) begin
            cnt_d++;
            last8_d = ws_d[8];
            if (q_d.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dflt_unexpected_window: got win8=%0d required no window", ws_d[8]);
            end else begin
                e = q_d.pop_front();
                check("dflt_window", 72'(ws_d), 72'(e.w));
`ifdef WINGEN_LAST_EN
                check("dflt_last", 72'(wl_d), 72'(e.last));
`endif
            end
        end
    end

    task automatic send_s(input logic v, input logic [7:0] p);
        exp_t e;
        pv_s  = v;
        pix_s = p;
        if (v) begin
            img_s[r_s][c_s] = p;
            if (r_s >= 2 && c_s >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[i*3+j] = img_s[r_s-2+i][c_s-2+j];
                e.last = (r_s == int'(SH) - 1) && (c_s == int'(SW) - 1);
                q_s.push_back(e);
            end
            if (c_s == int'(SW) - 1) begin
                c_s = 0;
                r_s = (r_s == int'(SH) - 1) ? 0 : r_s + 1;
            end else begin
                c_s++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_d(input logic [7:0] p);
        exp_t e;
        pv_d  = 1'b1;
        pix_d = p;
        if (r_d >= 2 && c_d >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.w[i*3+j] = pd(r_d - 2 + i, c_d - 2 + j);
            e.last = (r_d == int'(DH) - 1) && (c_d == int'(DW) - 1);
            q_d.push_back(e);
        end
        if (c_d == int'(DW) - 1) begin
            c_d = 0;
            r_d = (r_d == int'(DH) - 1) ? 0 : r_d + 1;
        end else begin
            c_d++;
        end
        @(posedge clk);
        #1;
        pv_d = 1'b0;
    endtask

    // Reset with pix_valid held high to show it is ignored.
    task automatic do_reset();
        rst_n = 1'b0;
        pv_s  = 1'b1;
        pix_s = 8'hAA;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pv_s  = 1'b0;
        r_s = 0; c_s = 0; r_d = 0; c_d = 0;
    endtask

    task automatic check_seq(input string name);
        int exp_seq[6] = '{12, 13, 14, 17, 18, 19};
        check({name, "_count"}, 72'(seq_s.size()), 72'(6));
        for (int i = 0; i < 6 && i < seq_s.size(); i++)
            check({name, "_win8"}, 72'(seq_s[i]), 72'(exp_seq[i]));
        seq_s.delete();
    endtask

    logic [8:0][7:0] first_win;
    logic [8:0][7:0] stall_win;

    initial begin
        int fw[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int sw[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        for (int i = 0; i < 9; i++) begin
            first_win[i] = 8'(fw[i]);
            stall_win[i] = 8'(sw[i]);
        end

        rst_n = 1'b0;
        pv_s  = 1'b1;
        pix_s = 8'h55;
        pv_d  = 1'b0;
        pix_d = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 72'(wv_s), 72'(0));
        check("reset_taps", 72'(ws_s), 72'(0));
`ifdef WINGEN_LAST_EN
        check("reset_last", 72'(wl_s), 72'(0));
`endif
        rst_n = 1'b1;
        pv_s  = 1'b0;
        send_s(1'b0, 8'h00);

        // First window and full-frame order.
        for (int p = 0; p < 20; p++) begin
            send_s(1'b1, 8'(p));
            if (p == 12) begin
                check("first_window_valid", 72'(wv_s), 72'(1));
                check("first_window", 72'(ws_s), 72'(first_win));
            end
        end
        send_s(1'b0, 8'h00);
        check_seq("frame_order");

        // Stall after pixel 13 holds taps and suppresses win_valid.
        for (int p = 0; p < 14; p++) send_s(1'b1, 8'(p));
        for (int k = 0; k < 3; k++) begin
            send_s(1'b0, 8'hFF);
            check("stall_valid", 72'(wv_s), 72'(0));
            check("stall_taps", 72'(ws_s), 72'(stall_win));
        end
        send_s(1'b1, 8'd14);
        check("stall_resume_valid", 72'(wv_s), 72'(1));
        check("stall_resume_win8", 72'(ws_s[8]), 72'(14));
        for (int p = 15; p < 20; p++) send_s(1'b1, 8'(p));
        send_s(1'b0, 8'h00);
        check_seq("stall_order");

        // Reset mid-frame after pixel 16, then a fresh frame.
        for (int p = 0; p < 17; p++) send_s(1'b1, 8'(p));
        do_reset();
        check("midreset_valid", 72'(wv_s), 72'(0));
        check("midreset_taps", 72'(ws_s), 72'(0));
        seq_s.delete();
        for (int p = 0; p < 20; p++) begin
            send_s(1'b1, 8'(p));
            if (p == 11) check("midreset_no_early_window", 72'(seq_s.size()), 72'(0));
            if (p == 12) check("midreset_first_window", 72'(ws_s), 72'(first_win));
        end
        send_s(1'b0, 8'h00);
        check_seq("midreset_order");

        // Back-to-back frames with no gap.
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 20; p++) begin
                send_s(1'b1, 8'(p));
                if (f == 1 && p == 12)
                    check("b2b_first_window", 72'(ws_s), 72'(first_win));
`ifdef WINGEN_LAST_EN
                if (p == 19) check("b2b_last", 72'(wl_s), 72'(1));
`endif
            end
        end
        send_s(1'b0, 8'h00);
        check("b2b_count", 72'(seq_s.size()), 72'(12));
        seq_s.delete();

        // Default-size ramp frame.
        do_reset();
        for (int r = 0; r < int'(DH); r++)
            for (int c = 0; c < int'(DW); c++)
                send_d(pd(r, c));
        repeat (2) @(posedge clk);
        #1;
        check("dflt_window_count", 72'(cnt_d), 72'(117216));
        check("dflt_last_win8", 72'(last8_d), 72'(118603 % 256));
        check("small_queue_drained", 72'(q_s.size()), 72'(0));
        check("dflt_queue_drained", 72'(q_d.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
